rv32i_reg_file: RTL and testbench
=================================

// Module: rv32i_reg_file
// PURPOSE
//  RV32I integer register file: 32 x 32-bit general-purpose registers (x0..x31).
//  Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
//  Sits in the decode/writeback boundary of the rv32i core.
//  x0 is hard-wired to zero. An instruction that does not write back steers rd = x0.
// PARAMETERS
//  XLEN    32   data width of each register
//  NREG    32   number of architectural registers (power of 2)
//  AW      5    address width, = $clog2(NREG)
// PORTS
//  i_clk     in   1     clock; all state updates on rising edge
//  i_rst_n   in   1     reset, asynchronous, active-low
//  i_wdata   in   XLEN  write data (rd value)
//  i_waddr   in   AW    write address (rd); 0 = no write
//  i_r1addr  in   AW    read port 1 address (rs1)
//  o_r1data  out  XLEN  read port 1 data
//  i_r2addr  in   AW    read port 2 address (rs2)
//  o_r2data  out  XLEN  read port 2 data
// BEHAVIOUR
//  - Reset: i_rst_n low clears x1..x31 to 0 immediately, independent of i_clk.
//    Reset has priority over any write. Outputs read 0 for all addresses while reset is low.
//  - Write: there is no write-enable. On every i_clk rising edge with i_rst_n high:
//      regs[i_waddr] <= i_wdata.
//    If i_waddr == 0, the write is discarded.
//  - Read: purely combinational, zero latency:
//      o_rNdata = (i_rNaddr == 0) ? 0 : regs[i_rNaddr]
//    Reads are X-free for every address once reset has been applied.
//  - Read-during-write to the same address, same cycle:
//      before the edge the read returns the old value;
//      after the edge the read returns the new value (no internal bypass).
//    The forwarding network upstream handles same-cycle bypass.
//  - Both read ports are fully independent. Both may address the same register,
//    including the register being written.
//  - x0 does not exist as storage; only x1..x31 are flops.
// STRUCTURE
//  - Shared package rv32i_pkg:
//      XLEN, NREG, REG_AW constants;
//      typedef logic [XLEN-1:0] word_t;
//      typedef logic [REG_AW-1:0] reg_addr_t;
//      localparam reg_addr_t REG_ZERO = '0.
//  - One sub-module: rv32i_rf_read_port. It is the combinational zero-gated read mux
//    and is instantiated twice (rs1, rs2).
//  - Storage: flop array with an async-clear always block; a generate loop per register.
// TESTING
//  1. Reset: pulse i_rst_n low mid-run -> o_r1data/o_r2data read 0 for all 32 addresses.
//  2. Basic write and read on both ports:
//      waddr=0x12, wdata=0xDEADBEEF, r1addr=r2addr=0x12 -> both ports 0xDEADBEEF after edge;
//      waddr=0x13, wdata=0xBABECAFE, r1addr=0x12, r2addr=0x13 -> 0xDEADBEEF / 0xBABECAFE.
//  3. x0 hard-wired:
//      waddr=0x00, wdata=0xBBC0FFEE, then waddr=0x01, wdata=0xEFBEADDE,
//      r1addr=0x00, r2addr=0x01 -> o_r1data=0, o_r2data=0xEFBEADDE.
//  4. Read-during-write on x5:
//      x5=0x11111111, then write 0x22222222 to x5 while reading x5 ->
//      0x11111111 before the edge, 0x22222222 after it.
//  5. Overwrite sweep: write each xN with N*0x01010101, then read all pairs (N, 31-N) ->
//      expected values, x0 = 0.
//  6. Async reset during an active write cycle:
//      assert i_rst_n low between edges -> immediate clear;
//      the write at the next edge is ignored while reset is held low.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types for the decode/writeback datapath.
// The register file and its read ports import this package.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // True when an address names real storage (anything other than x0).
  function automatic logic is_real_reg(input reg_addr_t a);
    return a != REG_ZERO;
  endfunction

endpackage

// File: rtl/rv32i_rf_read_port.sv
// Combinational register-file read mux; x0 is gated to zero rather than stored.
// Instantiated once per read port (rs1, rs2).
module rv32i_rf_read_port
  import rv32i_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned NR = 32,
  parameter int unsigned AB = 5
) (
  input  logic [AB-1:0] addr,
  input  logic [DW-1:0] regs [NR],
  output logic [DW-1:0] data
);

  always_comb begin
    data = '0;
    if (addr != AB'(REG_ZERO)) data = regs[addr];
  end

endmodule

// File: rtl/rv32i_reg_file.sv
// RV32I integer register file: 31 flopped registers plus hard-wired x0,
// two zero-latency read ports and one write port steered off by rd = x0.
module rv32i_reg_file
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = rv32i_pkg::XLEN,
  parameter int unsigned NREG = rv32i_pkg::NREG,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_waddr,
  input  logic [AW-1:0]   i_r1addr,
  output logic [XLEN-1:0] o_r1data,
  input  logic [AW-1:0]   i_r2addr,
  output logic [XLEN-1:0] o_r2data
);

  logic [XLEN-1:0] rf [NREG];

  // Slot 0 is a constant so the read muxes see a uniform array; no flop backs it.
  assign rf[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic [XLEN-1:0] q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        q <= '0;
      end else if (i_waddr == AW'(i)) begin
        q <= i_wdata;
      end
    end

    assign rf[i] = q;
  end

  rv32i_rf_read_port #(
    .DW (XLEN),
    .NR (NREG),
    .AB (AW)
  ) u_rs1 (
    .addr (i_r1addr),
    .regs (rf),
    .data (o_r1data)
  );

  rv32i_rf_read_port #(
    .DW (XLEN),
    .NR (NREG),
    .AB (AW)
  ) u_rs2 (
    .addr (i_r2addr),
    .regs (rf),
    .data (o_r2data)
  );

endmodule

// File: tb/tb_rv32i_reg_file.sv
// Scoreboard bench for rv32i_reg_file: stimulus queues hand-computed read values,
// an independent monitor compares them against both read ports.
module tb_rv32i_reg_file;

  logic        clk;
  logic        rst_n;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic [4:0]  r1addr;
  logic [31:0] r1data;
  logic [4:0]  r2addr;
  logic [31:0] r2data;

  rv32i_reg_file #(
    .XLEN (32),
    .NREG (32),
    .AW   (5)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wdata  (wdata),
    .i_waddr  (waddr),
    .i_r1addr (r1addr),
    .o_r1data (r1data),
    .i_r2addr (r2addr),
    .o_r2data (r2data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  bit   done   = 1'b0;

  // Monitor: inputs are held for 2 time units after each push, so a 1-unit
  // poll always samples the read ports while the queued entry's addresses apply.
  initial begin
    exp_t e;
    while (!done) begin
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (r1data === e.e1 && r2data === e.e2 && r1addr == e.a1 && r2addr == e.a2) begin
          passes++;
        end else begin
          $display("FAIL %s: r1[%0d]=%h r2[%0d]=%h, required r1[%0d]=%h r2[%0d]=%h",
                   e.name, r1addr, r1data, r2addr, r2data, e.a1, e.e1, e.a2, e.e2);
        end
      end
    end
  end

  task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name;
    e.a1   = r1addr;
    e.a2   = r2addr;
    e.e1   = e1;
    e.e2   = e2;
    q.push_back(e);
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    waddr = a;
    wdata = d;
    step();
    waddr = 5'd0;
  endtask

  initial begin
    rst_n  = 1'b1;
    wdata  = '0;
    waddr  = '0;
    r1addr = '0;
    r2addr = '0;
    #1 rst_n = 1'b0;
    #1;
    expect_rd("reset_init", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic write/read on both ports
    r1addr = 5'h12; r2addr = 5'h12;
    wr(5'h12, 32'hDEADBEEF);
    expect_rd("wr12_both", 32'hDEADBEEF, 32'hDEADBEEF);
    r1addr = 5'h12; r2addr = 5'h13;
    wr(5'h13, 32'hBABECAFE);
    expect_rd("wr13_pair", 32'hDEADBEEF, 32'hBABECAFE);

    // x0 hard-wired
    wr(5'h00, 32'hBBC0FFEE);
    r1addr = 5'h00; r2addr = 5'h00;
    expect_rd("x0_after_wr", 32'h0, 32'h0);
    wr(5'h01, 32'hEFBEADDE);
    r1addr = 5'h00; r2addr = 5'h01;
    expect_rd("x0_x1", 32'h0, 32'hEFBEADDE);

    // Read-during-write on x5: old value before the edge, new one after
    wr(5'h05, 32'h11111111);
    r1addr = 5'h05; r2addr = 5'h05;
    waddr = 5'h05; wdata = 32'h22222222;
    expect_rd("rdw_before", 32'h11111111, 32'h11111111);
    step();
    waddr = 5'h00;
    expect_rd("rdw_after", 32'h22222222, 32'h22222222);

    // Overwrite sweep, then read pairs (n, 31-n)
    for (int n = 0; n < 32; n++) wr(5'(n), 32'(n) * 32'h01010101);
    for (int n = 0; n < 32; n++) begin
      r1addr = 5'(n);
      r2addr = 5'(31 - n);
      expect_rd("sweep", 32'(n) * 32'h01010101, 32'(31 - n) * 32'h01010101);
    end

    // Async reset in the middle of a write cycle
    r1addr = 5'h07; r2addr = 5'h12;
    waddr = 5'h07; wdata = 32'hAAAA5555;
    #2 rst_n = 1'b0;
    #1;
    expect_rd("async_clear", 32'h0, 32'h0);
    step();
    expect_rd("wr_during_reset", 32'h0, 32'h0);
    waddr = 5'h00;
    for (int n = 0; n < 32; n++) begin
      r1addr = 5'(n);
      r2addr = 5'(31 - n);
      expect_rd("reset_sweep", 32'h0, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    r1addr = 5'h07; r2addr = 5'h1F;
    expect_rd("post_reset", 32'h0, 32'h0);
    wr(5'h1F, 32'h0F0F0F0F);
    expect_rd("post_reset_wr", 32'h0, 32'h0F0F0F0F);

    #5;
    if (q.size() != 0) begin
      $display("FAIL monitor_drain: %0d entries left, required 0", q.size());
      checks += q.size();
    end
    done = 1'b1;
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time %0t, required finish before 50000", $time);
    $fatal(1);
  end

endmodule
